// File: rtl/rst_seq_ctrl_if.sv
// Reset sequencer bus: request inputs, live timing config, and the
// per-domain reset / status outputs of rst_seq_ctrl.
interface rst_seq_ctrl_if #(
   parameter int NDOM = 3,
   parameter int CNTW = 8
);
   logic            prog_rst_ni;
   logic            ndmreset_i;
   logic            sw_rst_req_i;
   logic [CNTW-1:0] hold_cfg_i;
   logic [CNTW-1:0] gap_cfg_i;
   logic [NDOM-1:0] dom_rst_no;
   logic            busy_o;
   logic [3:0]      rst_cause_o;

   // Requester / configuration side
   modport master (
      output prog_rst_ni, ndmreset_i, sw_rst_req_i, hold_cfg_i, gap_cfg_i,
      input  dom_rst_no, busy_o, rst_cause_o
   );

   // Sequencer side
   modport slave (
      input  prog_rst_ni, ndmreset_i, sw_rst_req_i, hold_cfg_i, gap_cfg_i,
      output dom_rst_no, busy_o, rst_cause_o
   );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domains in reset for H cycles after the last
// request, then releases domains 0..NDOM-1 in order, G cycles apart.
// Any request (programmer, debug ndmreset, software) restarts the sequence
// and is recorded in the reset-cause register.
module rst_seq_ctrl #(
   parameter int NDOM = 3,
   parameter int CNTW = 8
) (
   input logic           clk_i,
   input logic           rst_i,
   rst_seq_ctrl_if.slave bus
);

   localparam int IDXW = (NDOM > 1) ? $clog2(NDOM) : 1;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [NDOM-1:0] dom_q, dom_d;
   logic            busy_q, busy_d;
   logic [3:0]      cause_q, cause_d;

   logic            req_s;
   logic [3:0]      cause_req_s;
   logic [CNTW-1:0] hold_eff_s;
   logic [CNTW-1:0] gap_eff_s;
   logic [CNTW:0]   cnt_inc_s;
   logic [CNTW-1:0] cnt_sat_s;
   logic            hold_done_s;
   logic            gap_done_s;
   logic            last_s;
   logic [NDOM:0]   dom_shift_s;

   // Request decode, live config (0 means 1), saturating count and compares
   always_comb begin
      req_s       = (~bus.prog_rst_ni) | bus.ndmreset_i | bus.sw_rst_req_i;
      cause_req_s = {bus.sw_rst_req_i, bus.ndmreset_i, ~bus.prog_rst_ni, 1'b0};
      hold_eff_s  = (bus.hold_cfg_i == {CNTW{1'b0}}) ? CNTW'(1) : bus.hold_cfg_i;
      gap_eff_s   = (bus.gap_cfg_i == {CNTW{1'b0}}) ? CNTW'(1) : bus.gap_cfg_i;
      // Compare in CNTW+1 bits so counter+1 never aliases to zero
      cnt_inc_s   = {1'b0, cnt_q} + (CNTW+1)'(1);
      cnt_sat_s   = (&cnt_q) ? cnt_q : (cnt_q + CNTW'(1));
      hold_done_s = (cnt_inc_s >= {1'b0, hold_eff_s});
      gap_done_s  = (cnt_inc_s >= {1'b0, gap_eff_s});
      last_s      = ((int'(idx_q) + 1) >= (NDOM - 1));
      // Releasing the next domain in order is a shift-in of a one
      dom_shift_s = {dom_q, 1'b1};
   end

   // Next-state logic: reset overrides requests, requests override release
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      dom_d   = dom_q;
      cause_d = cause_q;
      if (rst_i) begin
         state_d = ST_HOLD;
         cnt_d   = {CNTW{1'b0}};
         idx_d   = {IDXW{1'b0}};
         dom_d   = {NDOM{1'b0}};
         cause_d = 4'b0001;
      end else if (req_s) begin
         state_d = ST_HOLD;
         cnt_d   = {CNTW{1'b0}};
         idx_d   = {IDXW{1'b0}};
         dom_d   = {NDOM{1'b0}};
         // Repeated requests while holding accumulate; a fresh one overwrites
         if (state_q == ST_HOLD) begin
            cause_d = cause_q | cause_req_s;
         end else begin
            cause_d = cause_req_s;
         end
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (hold_done_s) begin
                  dom_d   = dom_shift_s[NDOM-1:0];
                  cnt_d   = {CNTW{1'b0}};
                  idx_d   = {IDXW{1'b0}};
                  state_d = (NDOM == 1) ? ST_RUN : ST_RELEASE;
               end else begin
                  cnt_d = cnt_sat_s;
               end
            end
            ST_RELEASE: begin
               if (gap_done_s) begin
                  dom_d   = dom_shift_s[NDOM-1:0];
                  idx_d   = idx_q + IDXW'(1);
                  cnt_d   = {CNTW{1'b0}};
                  state_d = last_s ? ST_RUN : ST_RELEASE;
               end else begin
                  cnt_d = cnt_sat_s;
               end
            end
            ST_RUN: begin
               cnt_d = {CNTW{1'b0}};
            end
            default: begin
               state_d = ST_HOLD;
               cnt_d   = {CNTW{1'b0}};
               idx_d   = {IDXW{1'b0}};
               dom_d   = {NDOM{1'b0}};
            end
         endcase
      end
      busy_d = (state_d != ST_RUN);
   end

   // State, counters and registered outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_HOLD;
         cnt_q   <= {CNTW{1'b0}};
         idx_q   <= {IDXW{1'b0}};
         dom_q   <= {NDOM{1'b0}};
         busy_q  <= 1'b1;
         cause_q <= 4'b0001;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         dom_q   <= dom_d;
         busy_q  <= busy_d;
         cause_q <= cause_d;
      end
   end

   assign bus.dom_rst_no  = dom_q;
   assign bus.busy_o      = busy_q;
   assign bus.rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl (NDOM=3, CNTW=8) with hand-computed
// expectations for power-on sequencing, each request source, live config,
// zero config, and a long hold with a mid-count reset.
module tb_rst_seq_ctrl;

   logic clk;
   logic rst;
   int   checks_r;
   int   errors_r;

   rst_seq_ctrl_if #(.NDOM(3), .CNTW(8)) bus ();

   rst_seq_ctrl #(.NDOM(3), .CNTW(8)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_r++;
      if (obs !== exp) begin
         errors_r++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_out(input string tag, input logic [2:0] dom, input logic busy, input logic [3:0] cause);
      check_val({tag, "_dom"}, 32'(bus.dom_rst_no), 32'(dom));
      check_val({tag, "_busy"}, 32'(bus.busy_o), 32'(busy));
      check_val({tag, "_cause"}, 32'(bus.rst_cause_o), 32'(cause));
   endtask

   // Directed stimulus; inputs change 1 ns after each rising edge
   initial begin
      checks_r         = 0;
      errors_r         = 0;
      rst              = 1'b1;
      bus.prog_rst_ni  = 1'b1;
      bus.ndmreset_i   = 1'b0;
      bus.sw_rst_req_i = 1'b0;
      bus.hold_cfg_i   = 8'd16;
      bus.gap_cfg_i    = 8'd4;

      // Power-on: H=16, G=4
      tick(3);
      check_out("por_reset", 3'b000, 1'b1, 4'b0001);
      rst = 1'b0;
      tick(15);
      check_out("por_e15", 3'b000, 1'b1, 4'b0001);
      tick(1);
      check_out("por_e16", 3'b001, 1'b1, 4'b0001);
      tick(3);
      check_out("por_e19", 3'b001, 1'b1, 4'b0001);
      tick(1);
      check_out("por_e20", 3'b011, 1'b1, 4'b0001);
      tick(3);
      check_out("por_e23", 3'b011, 1'b1, 4'b0001);
      tick(1);
      check_out("por_e24", 3'b111, 1'b0, 4'b0001);

      // Software pulse in RUN: H=2, G=1
      bus.hold_cfg_i   = 8'd2;
      bus.gap_cfg_i    = 8'd1;
      tick(2);
      check_out("run_idle", 3'b111, 1'b0, 4'b0001);
      bus.sw_rst_req_i = 1'b1;
      tick(1);
      bus.sw_rst_req_i = 1'b0;
      check_out("sw_hit", 3'b000, 1'b1, 4'b1000);
      tick(1);
      check_out("sw_e1", 3'b000, 1'b1, 4'b1000);
      tick(1);
      check_out("sw_e2", 3'b001, 1'b1, 4'b1000);
      tick(1);
      check_out("sw_e3", 3'b011, 1'b1, 4'b1000);
      tick(1);
      check_out("sw_e4", 3'b111, 1'b0, 4'b1000);

      // ndmreset held 10 cycles while RELEASE idx=1: H=2, G=4
      bus.gap_cfg_i    = 8'd4;
      bus.sw_rst_req_i = 1'b1;
      tick(1);
      bus.sw_rst_req_i = 1'b0;
      tick(2);
      check_val("ndm_pre_e2", 32'(bus.dom_rst_no), 32'(3'b001));
      tick(4);
      check_out("ndm_pre_e6", 3'b011, 1'b1, 4'b1000);
      bus.ndmreset_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check_out("ndm_hold", 3'b000, 1'b1, 4'b0100);
      end
      bus.ndmreset_i = 1'b0;
      tick(1);
      check_val("ndm_post_e1", 32'(bus.dom_rst_no), 32'(3'b000));
      tick(1);
      check_val("ndm_post_e2", 32'(bus.dom_rst_no), 32'(3'b001));
      tick(3);
      check_val("ndm_post_e5", 32'(bus.dom_rst_no), 32'(3'b001));
      tick(1);
      check_val("ndm_post_e6", 32'(bus.dom_rst_no), 32'(3'b011));
      tick(4);
      check_out("ndm_post_e10", 3'b111, 1'b0, 4'b0100);

      // Zero config behaves as H=1, G=1
      bus.hold_cfg_i = 8'd0;
      bus.gap_cfg_i  = 8'd0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_out("zero_reset", 3'b000, 1'b1, 4'b0001);
      tick(1);
      check_val("zero_e1", 32'(bus.dom_rst_no), 32'(3'b001));
      tick(1);
      check_val("zero_e2", 32'(bus.dom_rst_no), 32'(3'b011));

      // prog_rst_ni drops on the edge domain 2 would release
      bus.prog_rst_ni = 1'b0;
      tick(1);
      check_out("prog_collide", 3'b000, 1'b1, 4'b0010);
      // Further request while holding accumulates cause bits
      bus.ndmreset_i = 1'b1;
      tick(1);
      check_out("hold_or", 3'b000, 1'b1, 4'b0110);
      bus.prog_rst_ni = 1'b1;
      bus.ndmreset_i  = 1'b0;
      tick(1);
      check_out("prog_post_e1", 3'b001, 1'b1, 4'b0110);

      // Live config: lowering H below the current count ends the hold
      bus.hold_cfg_i   = 8'd200;
      bus.gap_cfg_i    = 8'd1;
      bus.sw_rst_req_i = 1'b1;
      tick(1);
      bus.sw_rst_req_i = 1'b0;
      tick(10);
      check_val("live_e10", 32'(bus.dom_rst_no), 32'(3'b000));
      bus.hold_cfg_i = 8'd3;
      tick(1);
      check_val("live_e11", 32'(bus.dom_rst_no), 32'(3'b001));

      // H=255 exact, with a reset at edge 100 restarting the count
      bus.hold_cfg_i   = 8'd255;
      bus.sw_rst_req_i = 1'b1;
      tick(1);
      bus.sw_rst_req_i = 1'b0;
      check_out("h255_req", 3'b000, 1'b1, 4'b1000);
      tick(99);
      check_out("h255_e99", 3'b000, 1'b1, 4'b1000);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_out("h255_rst", 3'b000, 1'b1, 4'b0001);
      tick(254);
      check_val("h255_e254", 32'(bus.dom_rst_no), 32'(3'b000));
      tick(1);
      check_out("h255_e255", 3'b001, 1'b1, 4'b0001);
      tick(1);
      check_val("h255_e256", 32'(bus.dom_rst_no), 32'(3'b011));

      $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
      $finish;
   end

endmodule
